// File: rtl/ctx_accum_sequencer_if.sv
// Handshake bundle for ctx_accum_sequencer: request/beat input side and result output side.
// The sequencer takes the slave modport; the producer/consumer side takes master.
interface ctx_accum_sequencer_if #(
    parameter int N_TOK = 16,
    parameter int DW    = 16,
    parameter int ACC_W = 40
);
    localparam int IW = $clog2(N_TOK);

    logic             start;
    logic             busy;
    logic             in_valid;
    logic             in_ready;
    logic [DW-1:0]    in_attn;
    logic [DW-1:0]    in_val;
    logic [IW-1:0]    in_idx;
    logic             out_valid;
    logic             out_ready;
    logic [DW-1:0]    out_ci;
    logic [ACC_W-1:0] out_sum;
    logic             out_div0;

    modport master (
        output start, in_valid, in_attn, in_val, out_ready,
        input  busy, in_ready, in_idx, out_valid, out_ci, out_sum, out_div0
    );

    modport slave (
        input  start, in_valid, in_attn, in_val, out_ready,
        output busy, in_ready, in_idx, out_valid, out_ci, out_sum, out_div0
    );
endinterface

// File: rtl/ctx_accum_sequencer.sv
// Contextualization sequencer: one shared MAC over N_TOK (attention, value) beats, then
// c_i = acc / sum via a restoring divider when CTX_SEQ_NORM_EN is defined (else c_i = sat(acc)).
module ctx_accum_sequencer #(
    parameter int N_TOK = 16,
    parameter int DW    = 16,
    parameter int ACC_W = 40
) (
    input logic                  clk,
    input logic                  reset,
    ctx_accum_sequencer_if.slave bus
);
    localparam int            IW       = $clog2(N_TOK);
    localparam logic [IW-1:0] LAST_TOK = IW'(N_TOK - 1);

`ifdef CTX_SEQ_NORM_EN
    localparam int CW = $clog2(ACC_W + 1);
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCUM  = 2'd1,
        S_DIVIDE = 2'd2,
        S_OUTPUT = 2'd3
    } state_e;
`else
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCUM  = 2'd1,
        S_OUTPUT = 2'd3
    } state_e;
`endif

    state_e           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [ACC_W-1:0] sum_q, sum_d;
    logic [IW-1:0]    tok_q, tok_d;
    logic [DW-1:0]    out_ci_q, out_ci_d;
    logic [ACC_W-1:0] out_sum_q, out_sum_d;
    logic             out_div0_q, out_div0_d;
    logic [2*DW-1:0]  prod;
    logic             in_ready;

`ifdef CTX_SEQ_NORM_EN
    // acc_q doubles as the dividend/quotient shift register during DIVIDE
    logic [ACC_W-1:0] rem_q, rem_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [ACC_W:0]   rem_sh;
    logic             qbit;
`else
    // one-cycle pause after the last beat so the result registers load from a settled acc
    logic             fin_q, fin_d;
`endif

    function automatic logic [DW-1:0] sat(input logic [ACC_W-1:0] x);
        return (|x[ACC_W-1:DW]) ? {DW{1'b1}} : x[DW-1:0];
    endfunction

    assign prod = {{DW{1'b0}}, bus.in_attn} * {{DW{1'b0}}, bus.in_val};

`ifdef CTX_SEQ_NORM_EN
    assign in_ready = (state_q == S_ACCUM);
`else
    assign in_ready = (state_q == S_ACCUM) && !fin_q;
`endif

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        sum_d      = sum_q;
        tok_d      = tok_q;
        out_ci_d   = out_ci_q;
        out_sum_d  = out_sum_q;
        out_div0_d = out_div0_q;
`ifdef CTX_SEQ_NORM_EN
        rem_d      = rem_q;
        cnt_d      = cnt_q;
        rem_sh     = {rem_q, acc_q[ACC_W-1]};
        qbit       = 1'b0;
`else
        fin_d      = fin_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    acc_d   = '0;
                    sum_d   = '0;
                    tok_d   = '0;
                    state_d = S_ACCUM;
                end
            end
            S_ACCUM: begin
`ifndef CTX_SEQ_NORM_EN
                if (fin_q) begin
                    out_ci_d   = sat(acc_q);
                    out_sum_d  = sum_q;
                    out_div0_d = 1'b0;
                    fin_d      = 1'b0;
                    state_d    = S_OUTPUT;
                end else
`endif
                if (bus.in_valid) begin
                    acc_d = acc_q + {{(ACC_W-2*DW){1'b0}}, prod};
                    sum_d = sum_q + {{(ACC_W-DW){1'b0}}, bus.in_attn};
                    tok_d = tok_q + 1'b1;
                    if (tok_q == LAST_TOK) begin
`ifdef CTX_SEQ_NORM_EN
                        rem_d   = '0;
                        cnt_d   = '0;
                        state_d = S_DIVIDE;
`else
                        fin_d   = 1'b1;
`endif
                    end
                end
            end
`ifdef CTX_SEQ_NORM_EN
            S_DIVIDE: begin
                if (cnt_q == CW'(ACC_W)) begin
                    out_ci_d   = sat(acc_q);
                    out_sum_d  = sum_q;
                    out_div0_d = (sum_q == '0);
                    state_d    = S_OUTPUT;
                end else begin
                    // sum == 0 makes every compare succeed, so the quotient is all ones
                    if (rem_sh >= {1'b0, sum_q}) begin
                        qbit  = 1'b1;
                        rem_d = rem_sh[ACC_W-1:0] - sum_q;
                    end else begin
                        rem_d = rem_sh[ACC_W-1:0];
                    end
                    acc_d = {acc_q[ACC_W-2:0], qbit};
                    cnt_d = cnt_q + 1'b1;
                end
            end
`endif
            S_OUTPUT: begin
                if (bus.out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            acc_q      <= '0;
            sum_q      <= '0;
            tok_q      <= '0;
            out_ci_q   <= '0;
            out_sum_q  <= '0;
            out_div0_q <= 1'b0;
`ifdef CTX_SEQ_NORM_EN
            rem_q      <= '0;
            cnt_q      <= '0;
`else
            fin_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            sum_q      <= sum_d;
            tok_q      <= tok_d;
            out_ci_q   <= out_ci_d;
            out_sum_q  <= out_sum_d;
            out_div0_q <= out_div0_d;
`ifdef CTX_SEQ_NORM_EN
            rem_q      <= rem_d;
            cnt_q      <= cnt_d;
`else
            fin_q      <= fin_d;
`endif
        end
    end

    assign bus.busy      = (state_q != S_IDLE);
    assign bus.in_ready  = in_ready;
    assign bus.in_idx    = tok_q;
    assign bus.out_valid = (state_q == S_OUTPUT);
    assign bus.out_ci    = out_ci_q;
    assign bus.out_sum   = out_sum_q;
    assign bus.out_div0  = out_div0_q;
endmodule
